stage2_mem_ctrl: RTL and testbench
==================================

Name: stage2_mem_ctrl

Overview:
Load/store controller in pipeline Stage 2. It converts the ALU-computed byte address and rs2 store data into word-aligned data-memory requests using a valid/ready handshake. It stalls the pipeline until the access completes, then delivers the extracted, sign- or zero-extended load data on dout. Stage 3 consumes dout through the Stage 2/3 transfer register for writeback.

Parameters:
ADDR_WIDTH, 32, byte-address width; dmem_req_addr is ADDR_WIDTH-2 bits (word address).

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
valid_in  input  1  Stage 2 holds a live instruction
inst  input  32  Stage 2 instruction; opcode inst[6:0], funct3 inst[14:12]
addr  input  ADDR_WIDTH  byte address (ALU result)
rs2_data  input  32  store source data
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  memory accepts request
dmem_req_addr  output  ADDR_WIDTH-2  word address, addr[ADDR_WIDTH-1:2]
dmem_req_we  output  4  byte write enables; 4'b0000 means read
dmem_req_wdata  output  32  lane-replicated store data
dmem_resp_valid  input  1  load response valid (one-cycle pulse)
dmem_resp_data  input  32  load response word
dout  output  32  extracted load data, held until the next load completes
stall  output  1  freeze Stage 1/2 and the 2/3 transfer register
misalign  output  1  misaligned access detected; access suppressed

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, dout=0, dmem_req_valid=0, dmem_req_we=0, dmem_req_wdata=0, dmem_req_addr=0, misalign=0.
  - Reset mid-access drops dmem_req_valid immediately. Any outstanding response is discarded.
- Memory op: valid_in & (opcode==LOAD | opcode==STORE).
- Misaligned access:
  - Definition: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0.
  - While in IDLE, misalign=valid_in & memop & misaligned (combinational). No request is issued, stall=0, dout is unchanged.
- States: IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
- IDLE:
  - A valid aligned memop latches word address, we, wdata, funct3 and addr[1:0] into registers and moves to REQ.
  - stall=1 combinationally in this same cycle.
- REQ:
  - dmem_req_valid=1 and the registered req fields are held stable until the handshake (valid & ready).
  - On the handshake: load -> WAIT; store -> DONE. Stores do not wait for a response.
  - stall=1.
- WAIT:
  - stall=1, dmem_req_valid=0.
  - On dmem_resp_valid: extract the load, register it into dout, go to DONE.
- DONE:
  - stall=0 for exactly one cycle; the pipeline advances at the end of it.
  - valid_in/inst are ignored here, so the same instruction is not relaunched. Next state is IDLE.
- Minimum latency: store 3 cycles (IDLE, REQ, DONE); load 4 cycles (IDLE, REQ, WAIT, DONE), plus wait cycles for ready/response.
- Store lanes, with off=addr[1:0]:
  - SB: wdata={4{rs2[7:0]}}, we=4'b0001<<off.
  - SH: wdata={2{rs2[15:0]}}, we=4'b0011<<off.
  - SW: wdata=rs2, we=4'b1111.
- Load extraction from resp word W, with off=latched addr[1:0]:
  - LB: sign-extend W[8*off+7:8*off]. LBU: zero-extend the same byte.
  - LH: sign-extend W[16*off[1]+15:16*off[1]]. LHU: zero-extend the same half.
  - LW: W.
- Unsupported funct3 on a memop: treated as LW/SW width.
- dmem_resp_valid outside WAIT is ignored.
- Non-memop, or valid_in=0: stall=0, no request, dout unchanged.

Test Plan:
- Reset mid-REQ -> dmem_req_valid drops the same cycle. After release, state IDLE and dout=0.
- LB addr=0x1003, resp 0x80FF_1234, ready immediate, resp one cycle after accept -> stall high 3 cycles, then dout=0xFFFF_FF80. LBU on the same access -> dout=0x0000_0080.
- SH addr=0x2002, rs2=0xDEAD_BEEF, ready held low 3 cycles -> req fields stable throughout: req_addr=0x800, we=4'b1100, wdata=0xBEEF_BEEF. DONE follows acceptance; dout unchanged.
- LW addr=0x0000_0006 -> misalign=1, stall=0, no dmem_req_valid, dout keeps its previous value.
- Back-to-back: LW 0x10 (resp 0x1234_5678) then SW 0x14 -> exactly two accepted requests, no relaunch during DONE. dout=0x1234_5678 after the first and unchanged by the store.
- Stray dmem_resp_valid during IDLE/REQ with data 0xFFFF_FFFF -> ignored; a later real response 0x0000_0042 yields dout=0x42 (LW).

Source files
------------

// File: rtl/stage2_mem_ctrl.sv
// -----------------------------------------------------------------------------
// stage2_mem_ctrl
//   Stage 2 load/store controller. Turns the ALU byte address and rs2 store
//   data into one word-aligned data-memory request, stalls the pipeline while
//   the access is in flight, and delivers the extracted and extended load data
//   on dout for Stage 3 writeback.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   valid_in          Stage 2 holds a live instruction
//   inst              instruction (opcode inst[6:0], funct3 inst[14:12])
//   addr              byte address from the ALU
//   rs2_data          store source data
//   dmem_req_*        request channel: valid/ready, word address, byte
//                     enables (0000 = read), lane-replicated write data
//   dmem_resp_*       load response: one-cycle valid pulse plus data word
//   dout              extracted load data, held until the next load completes
//   stall             freeze Stage 1/2 and the 2/3 transfer register
//   misalign          misaligned memop seen in IDLE; the access is suppressed
//   dbg_state         current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Handshake: a request transfers on the rising edge where dmem_req_valid and
// dmem_req_ready are both high. Once valid is raised it stays high, and the
// address/we/wdata stay unchanged, until that transfer; valid never depends
// combinationally on ready. dmem_resp_valid is only honoured in WAIT.
// -----------------------------------------------------------------------------
module stage2_mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [31:0]           inst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           rs2_data,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic [ADDR_WIDTH-3:0] dmem_req_addr,
    output logic [3:0]            dmem_req_we,
    output logic [31:0]           dmem_req_wdata,
    input  logic                  dmem_resp_valid,
    input  logic [31:0]           dmem_resp_data,
    output logic [31:0]           dout,
    output logic                  stall,
    output logic                  misalign,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t      state_q, state_d;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_load_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, memop, misaligned, launch;
    logic [1:0]  size;
    logic [3:0]  we_d;
    logic [31:0] wdata_d;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_word;

    // rd/rs fields are decoded elsewhere in Stage 2.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign memop    = valid_in & (is_load | is_store);

    // Access width; unsupported funct3 encodings fall back to a full word.
    always_comb begin
        size = SZ_W;
        if (is_load) begin
            case (funct3)
                3'b000, 3'b100: size = SZ_B;
                3'b001, 3'b101: size = SZ_H;
                default:        size = SZ_W;
            endcase
        end else begin
            case (funct3)
                3'b000:  size = SZ_B;
                3'b001:  size = SZ_H;
                default: size = SZ_W;
            endcase
        end
    end

    assign misaligned = ((size == SZ_W) && (addr[1:0] != 2'b00)) ||
                        ((size == SZ_H) && addr[0]);
    assign launch     = (state_q == IDLE) && memop && !misaligned;

    // Store byte enables and lane replication; loads issue we=0000.
    always_comb begin
        we_d    = 4'b0000;
        wdata_d = 32'h0;
        if (is_store) begin
            case (size)
                SZ_B: begin
                    we_d    = 4'b0001 << addr[1:0];
                    wdata_d = {4{rs2_data[7:0]}};
                end
                SZ_H: begin
                    we_d    = 4'b0011 << addr[1:0];
                    wdata_d = {2{rs2_data[15:0]}};
                end
                default: begin
                    we_d    = 4'b1111;
                    wdata_d = rs2_data;
                end
            endcase
        end
    end

    // Load extraction from the response word using the latched offset.
    always_comb begin
        case (off_q)
            2'd0:    lane_byte = dmem_resp_data[7:0];
            2'd1:    lane_byte = dmem_resp_data[15:8];
            2'd2:    lane_byte = dmem_resp_data[23:16];
            default: lane_byte = dmem_resp_data[31:24];
        endcase
        lane_half = off_q[1] ? dmem_resp_data[31:16] : dmem_resp_data[15:0];
        case (f3_q)
            3'b000:  load_word = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_word = {24'h0, lane_byte};
            3'b001:  load_word = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_word = {16'h0, lane_half};
            default: load_word = dmem_resp_data;
        endcase
    end

    // Next state and outputs.
    always_comb begin
        state_d        = state_q;
        stall          = 1'b0;
        misalign       = 1'b0;
        dmem_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                misalign = memop & misaligned;
                if (launch) begin
                    state_d = REQ;
                    stall   = 1'b1;
                end
            end
            REQ: begin
                dmem_req_valid = 1'b1;
                stall          = 1'b1;
                if (dmem_req_ready) state_d = is_load_q ? WAIT : DONE;
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_resp_valid) state_d = DONE;
            end
            // One unstalled cycle; valid_in is ignored so the same
            // instruction is not launched a second time.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            dmem_req_addr  <= '0;
            dmem_req_we    <= 4'b0000;
            dmem_req_wdata <= 32'h0;
            f3_q           <= 3'b000;
            off_q          <= 2'b00;
            is_load_q      <= 1'b0;
            dout           <= 32'h0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                dmem_req_addr  <= addr[ADDR_WIDTH-1:2];
                dmem_req_we    <= we_d;
                dmem_req_wdata <= wdata_d;
                f3_q           <= funct3;
                off_q          <= addr[1:0];
                is_load_q      <= is_load;
            end
            if ((state_q == WAIT) && dmem_resp_valid) dout <= load_word;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_stage2_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stage2_mem_ctrl
//   Table-driven bench for stage2_mem_ctrl: each row is one instruction with
//   its memory-side timing and expected request fields / load result, applied
//   back to back. Request expectations and dout expectations go into queues
//   when the instruction is driven and are popped when the DUT hands the
//   request over or finishes the access. Hand-written sequences cover reset.
// -----------------------------------------------------------------------------
module tb_stage2_mem_ctrl;

  localparam int AW = 32;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_NOP   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [31:0]   inst;
  logic [AW-1:0] addr;
  logic [31:0]   rs2_data;
  logic          dmem_req_valid;
  logic          dmem_req_ready;
  logic [AW-3:0] dmem_req_addr;
  logic [3:0]    dmem_req_we;
  logic [31:0]   dmem_req_wdata;
  logic          dmem_resp_valid;
  logic [31:0]   dmem_resp_data;
  logic [31:0]   dout;
  logic          stall;
  logic          misalign;
  logic [1:0]    dbg_state;

  stage2_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .inst            (inst),
    .addr            (addr),
    .rs2_data        (rs2_data),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_we     (dmem_req_we),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_data  (dmem_resp_data),
    .dout            (dout),
    .stall           (stall),
    .misalign        (misalign),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          kind;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] resp;
    int          ready_lat;
    int          resp_lat;
    logic        stray;
    logic        exp_mis;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t        vecs[$];
  logic [65:0] req_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_dout;
  int          checks = 0;
  int          errors = 0;
  int          accept_cnt = 0;
  int          exp_accepts = 0;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Request tuple as compared; write data only matters when a lane is enabled.
  function automatic logic [65:0] req_tuple(input logic [29:0] a, input logic [3:0] we,
                                            input logic [31:0] wd);
    return {a, we, (we != 4'b0000) ? wd : 32'h0};
  endfunction

  // Request monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset && dmem_req_valid && dmem_req_ready) begin
      accept_cnt++;
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got request addr %h we %b, expected none",
                 dmem_req_addr, dmem_req_we);
      end else begin
        chk("req_fields", req_tuple(dmem_req_addr, dmem_req_we, dmem_req_wdata),
            req_q.pop_front());
      end
    end
  end

  function automatic vec_t mkv(input string nm, input int kind, input logic [6:0] op,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] rs2, input logic [31:0] resp,
                               input int rl, input int pl, input logic stray,
                               input logic mis, input logic [3:0] we,
                               input logic [31:0] wd, input logic [31:0] d);
    vec_t v;
    v.name = nm; v.kind = kind; v.op = op; v.f3 = f3; v.addr = a; v.rs2 = rs2;
    v.resp = resp; v.ready_lat = rl; v.resp_lat = pl; v.stray = stray;
    v.exp_mis = mis; v.exp_we = we; v.exp_wdata = wd; v.exp_dout = d;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Starts on the edge that ends the previous instruction, so rows run back
  // to back and valid_in stays high through DONE with the old instruction.
  task automatic apply(input vec_t v);
    logic [16:0] hi;
    logic [4:0]  rd;
    hi = 17'($urandom_range(0, 17'h1FFFF));
    rd = 5'($urandom_range(0, 31));
    @(posedge clk); #1;
    valid_in        = 1'b1;
    inst            = {hi, v.f3, rd, v.op};
    addr            = v.addr;
    rs2_data        = v.rs2;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = v.stray;
    dmem_resp_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    chk({v.name, ":misalign"}, 66'(misalign), 66'(v.exp_mis));
    if (v.kind == K_NOP) begin
      chk({v.name, ":stall"}, 66'(stall), 66'(1'b0));
      chk({v.name, ":req_valid"}, 66'(dmem_req_valid), 66'(1'b0));
      chk({v.name, ":dout_kept"}, 66'(dout), 66'(model_dout));
      return;
    end
    chk({v.name, ":stall_idle"}, 66'(stall), 66'(1'b1));
    exp_accepts++;
    req_q.push_back(req_tuple(v.addr[31:2], v.exp_we, v.exp_wdata));
    if (v.kind == K_LOAD) model_dout = v.exp_dout;
    exp_q.push_back(model_dout);

    @(posedge clk); #1;
    for (int n = 0; n < v.ready_lat; n++) begin
      @(negedge clk);
      chk({v.name, ":req_hold"}, {63'h0, dmem_req_valid, stall, dout == model_dout ? 1'b0 : 1'b0},
          {63'h0, 1'b1, 1'b1, 1'b0});
      if (req_q.size() != 0)
        chk({v.name, ":req_stable"}, req_tuple(dmem_req_addr, dmem_req_we, dmem_req_wdata),
            req_q[0]);
      @(posedge clk); #1;
    end
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;

    if (v.kind == K_LOAD) begin
      for (int n = 0; n < v.resp_lat; n++) begin
        @(negedge clk);
        chk({v.name, ":wait"}, {64'h0, stall, dmem_req_valid}, {64'h0, 1'b1, 1'b0});
        @(posedge clk); #1;
      end
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = v.resp;
      @(posedge clk); #1;
      dmem_resp_valid = 1'b0;
      dmem_resp_data  = 32'hFFFF_FFFF;
    end

    @(negedge clk);
    chk({v.name, ":done"}, {64'h0, dbg_state}, {64'h0, 2'd3});
    chk({v.name, ":stall_done"}, 66'(stall), 66'(1'b0));
    chk({v.name, ":dout"}, 66'(dout), 66'(exp_q.pop_front()));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in        = 1'b0;
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b0;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    reset = 1'b1; valid_in = 1'b0; inst = 32'h0; addr = '0; rs2_data = 32'h0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = 32'h0;
    model_dout = 32'h0;

    //        name       kind     op        f3      addr          rs2           resp          rl pl st mis we       wdata         dout
    vecs.push_back(mkv("lb_neg",   K_LOAD,  OP_LOAD,  3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FF80));
    vecs.push_back(mkv("lbu",      K_LOAD,  OP_LOAD,  3'b100, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_0080));
    vecs.push_back(mkv("sh_hi",    K_STORE, OP_STORE, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        3, 0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0));
    vecs.push_back(mkv("lw_mis",   K_NOP,   OP_LOAD,  3'b010, 32'h0000_0006, 32'h0,        32'h0,         0, 0, 0, 1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mkv("lw_b2b",   K_LOAD,  OP_LOAD,  3'b010, 32'h0000_0010, 32'h0,        32'h1234_5678, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h1234_5678));
    vecs.push_back(mkv("sw_b2b",   K_STORE, OP_STORE, 3'b010, 32'h0000_0014, 32'hA5A5_5A5A, 32'h0,        0, 0, 0, 0, 4'b1111, 32'hA5A5_5A5A, 32'h0));
    vecs.push_back(mkv("lw_stray", K_LOAD,  OP_LOAD,  3'b010, 32'h0000_0020, 32'h0,        32'h0000_0042, 2, 1, 1, 0, 4'b0000, 32'h0,        32'h0000_0042));
    vecs.push_back(mkv("lh_neg",   K_LOAD,  OP_LOAD,  3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 2, 0, 0, 4'b0000, 32'h0,        32'hFFFF_8001));
    vecs.push_back(mkv("lhu_lo",   K_LOAD,  OP_LOAD,  3'b101, 32'h0000_0100, 32'h0,        32'h8001_F00D, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_F00D));
    vecs.push_back(mkv("sb_off1",  K_STORE, OP_STORE, 3'b000, 32'h0000_3001, 32'h1234_56C3, 32'h0,        1, 0, 0, 0, 4'b0010, 32'hC3C3_C3C3, 32'h0));
    vecs.push_back(mkv("lh_mis",   K_NOP,   OP_LOAD,  3'b001, 32'h0000_0101, 32'h0,        32'h0,         0, 0, 0, 1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mkv("sb_off3",  K_STORE, OP_STORE, 3'b000, 32'h0000_3003, 32'h0000_0011, 32'h0,        0, 0, 0, 0, 4'b1000, 32'h1111_1111, 32'h0));
    vecs.push_back(mkv("lb_pos",   K_LOAD,  OP_LOAD,  3'b000, 32'h0000_1001, 32'h0,        32'h80FF_1234, 0, 1, 0, 0, 4'b0000, 32'h0,        32'h0000_0012));
    vecs.push_back(mkv("ld_f3_6",  K_LOAD,  OP_LOAD,  3'b110, 32'h0000_0030, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 0, 4'b0000, 32'h0,        32'hCAFE_F00D));
    vecs.push_back(mkv("ld_f3_7m", K_NOP,   OP_LOAD,  3'b111, 32'h0000_0032, 32'h0,        32'h0,         0, 0, 0, 1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mkv("st_f3_4",  K_STORE, OP_STORE, 3'b100, 32'h0000_0040, 32'h0BAD_CAFE, 32'h0,        0, 0, 0, 0, 4'b1111, 32'h0BAD_CAFE, 32'h0));
    vecs.push_back(mkv("alu_op",   K_NOP,   OP_ALU,   3'b000, 32'h0000_0003, 32'h0,        32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,        32'h0));

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {64'h0, dbg_state}, 66'h0);
    chk("reset_dout", 66'(dout), 66'h0);
    chk("reset_req", req_tuple(dmem_req_addr, dmem_req_we, dmem_req_wdata), 66'h0);
    chk("reset_flags", {63'h0, dmem_req_valid, stall, misalign}, 66'h0);
    chk("reset_wdata", 66'(dmem_req_wdata), 66'h0);

    // Table, back to back
    foreach (vecs[i]) apply(vecs[i]);
    idle_cycles(3);
    chk("accept_count", 66'(accept_cnt), 66'(exp_accepts));

    // Reset in the middle of REQ: valid drops with reset, dout clears
    @(posedge clk); #1;
    valid_in = 1'b1; inst = {17'h0, 3'b010, 5'd1, OP_LOAD}; addr = 32'h0000_0050;
    dmem_req_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_req_valid", 66'(dmem_req_valid), 66'(1'b1));
    #1 reset = 1'b1; valid_in = 1'b0;
    #1;
    chk("rst_drop_valid", 66'(dmem_req_valid), 66'(1'b0));
    chk("rst_state", {64'h0, dbg_state}, 66'h0);
    chk("rst_dout", 66'(dout), 66'h0);
    // A response arriving around reset must be discarded.
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'hFFFF_FFFF;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_state", {64'h0, dbg_state}, 66'h0);
    chk("post_rst_dout", 66'(dout), 66'h0);
    chk("post_rst_stall", 66'(stall), 66'(1'b0));
    idle_cycles(2);
    chk("final_accepts", 66'(accept_cnt), 66'(exp_accepts));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
